// File: rtl/result_demux8_pkg.sv
// ============================================================================
// result_demux8_pkg : shared constants and popcount helper for result_demux8
// Rev 1.0
// ============================================================================
`default_nettype none

package result_demux8_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int NSLOT_FIXED   = 8;
  localparam int SEL_W         = 3;
  localparam int CNT_W         = 4;

  function automatic logic [CNT_W-1:0] popcount8(input logic [NSLOT_FIXED-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NSLOT_FIXED; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_demux8_slot.sv
// ============================================================================
// demux_slot : one destination slot, data register plus valid flag
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             valid_nxt
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // A write beats a same-cycle clear; a clear never touches the data.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout      = data_q;
  assign valid     = valid_q;
  assign valid_nxt = valid_d;

endmodule

`default_nettype wire

// File: rtl/result_demux8.sv
// ============================================================================
// result_demux8 : routes a result word into one of eight registered slots
// Rev 1.0
// ============================================================================
`default_nettype none

module result_demux8
  import result_demux8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NSLOT = NSLOT_FIXED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       control,
  input  logic             wr_en,
  input  logic [7:0]       clr,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [7:0]       valid,
  output logic [3:0]       pending,
  output logic             overwrite
);

  logic [NSLOT-1:0] wr_sel;
  logic [NSLOT-1:0] valid_nxt;
  logic [WIDTH-1:0] data [NSLOT];

  logic             overwrite_d, overwrite_q;
  logic [CNT_W-1:0] pending_d, pending_q;

  always_comb begin
    wr_sel = '0;
    if (wr_en) begin
      wr_sel[control] = 1'b1;
    end
  end

  // Counting the slots' next-state valids keeps pending in step with valid.
  always_comb begin
    overwrite_d = wr_en & valid[control] & ~clr[control];
    pending_d   = popcount8(valid_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overwrite_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      overwrite_q <= overwrite_d;
      pending_q   <= pending_d;
    end
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_sel[i]),
      .clr      (clr[i]),
      .din      (in),
      .dout     (data[i]),
      .valid    (valid[i]),
      .valid_nxt(valid_nxt[i])
    );
  end

  assign o0        = data[0];
  assign o1        = data[1];
  assign o2        = data[2];
  assign o3        = data[3];
  assign o4        = data[4];
  assign o5        = data[5];
  assign o6        = data[6];
  assign o7        = data[7];
  assign pending   = pending_q;
  assign overwrite = overwrite_q;

endmodule

`default_nettype wire

// File: tb/tb_result_demux8.sv
// ============================================================================
// tb_result_demux8 : directed self-checking bench for result_demux8
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_result_demux8;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic [2:0]  control;
  logic        wr_en;
  logic [7:0]  clr;
  logic [15:0] o [8];
  logic [7:0]  valid;
  logic [3:0]  pending;
  logic        overwrite;

  int n_checks;
  int n_fail;

  result_demux8 #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .control  (control),
    .wr_en    (wr_en),
    .clr      (clr),
    .o0       (o[0]),
    .o1       (o[1]),
    .o2       (o[2]),
    .o3       (o[3]),
    .o4       (o[4]),
    .o5       (o[5]),
    .o6       (o[6]),
    .o7       (o[7]),
    .valid    (valid),
    .pending  (pending),
    .overwrite(overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and sample 1 time unit after the capturing edge.
  task automatic cyc(input logic r, input logic we, input logic [2:0] ctl,
                     input logic [15:0] d, input logic [7:0] c);
    @(negedge clk);
    rst     = r;
    wr_en   = we;
    control = ctl;
    in      = d;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_o%0d", tag, i), 32'(o[i]), 32'h0);
    end
    check({tag, "_valid"},     32'(valid),     32'h0);
    check({tag, "_pending"},   32'(pending),   32'h0);
    check({tag, "_overwrite"}, 32'(overwrite), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; wr_en = 1'b0; control = 3'd0; in = 16'h0; clr = 8'h0;

    // Reset held two cycles while a write is presented
    cyc(1'b1, 1'b1, 3'd0, 16'hFFFF, 8'h00);
    cyc(1'b1, 1'b1, 3'd0, 16'hFFFF, 8'h00);
    check_all_zero("reset");

    // Fill all eight slots on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 3'(i), 16'h1000 + 16'(i), 8'h00);
      check($sformatf("fill_pending%0d", i), 32'(pending), 32'(i + 1));
      check($sformatf("fill_ovw%0d", i), 32'(overwrite), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_o%0d", i), 32'(o[i]), 32'h1000 + 32'(i));
    end
    check("fill_valid", 32'(valid), 32'hFF);

    // Idle cycle: everything holds, pending stays saturated at 8
    cyc(1'b0, 1'b0, 3'd5, 16'hDEAD, 8'h00);
    check("idle_valid",   32'(valid),   32'hFF);
    check("idle_pending", 32'(pending), 32'h8);
    check("idle_o5",      32'(o[5]),    32'h1005);

    // Overwrite without clear
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 8'h00);
    cyc(1'b0, 1'b1, 3'd3, 16'hABCD, 8'h00);
    check("ovw_first_ovw", 32'(overwrite), 32'h0);
    check("ovw_first_o3",  32'(o[3]),      32'hABCD);
    cyc(1'b0, 1'b1, 3'd3, 16'h1234, 8'h00);
    check("ovw_o3",      32'(o[3]),      32'h1234);
    check("ovw_pulse",   32'(overwrite), 32'h1);
    check("ovw_pending", 32'(pending),   32'h1);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 8'h00);
    check("ovw_pulse_end", 32'(overwrite), 32'h0);
    check("ovw_hold_o3",   32'(o[3]),      32'h1234);

    // Overwrite masked by same-slot clear: write wins, no flag
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 8'h00);
    cyc(1'b0, 1'b1, 3'd3, 16'hABCD, 8'h00);
    cyc(1'b0, 1'b1, 3'd3, 16'h1234, 8'h08);
    check("wrclr_ovw",     32'(overwrite), 32'h0);
    check("wrclr_valid",   32'(valid),     32'h08);
    check("wrclr_o3",      32'(o[3]),      32'h1234);
    check("wrclr_pending", 32'(pending),   32'h1);

    // Multi-bit clear keeps data
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 8'h00);
    cyc(1'b0, 1'b1, 3'd0, 16'h00A0, 8'h00);
    cyc(1'b0, 1'b1, 3'd5, 16'h00A5, 8'h00);
    cyc(1'b0, 1'b1, 3'd7, 16'h00A7, 8'h00);
    check("clr_pre_valid",   32'(valid),   32'hA1);
    check("clr_pre_pending", 32'(pending), 32'h3);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 8'hA1);
    check("clr_valid",   32'(valid),   32'h00);
    check("clr_pending", 32'(pending), 32'h0);
    check("clr_o0",      32'(o[0]),    32'h00A0);
    check("clr_o5",      32'(o[5]),    32'h00A5);
    check("clr_o7",      32'(o[7]),    32'h00A7);

    // Write to one slot while clearing two others in the same edge
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 8'h00);
    cyc(1'b0, 1'b1, 3'd1, 16'h0011, 8'h00);
    cyc(1'b0, 1'b1, 3'd2, 16'h0022, 8'h00);
    cyc(1'b0, 1'b1, 3'd4, 16'h4444, 8'h06);
    check("conc_valid",   32'(valid),     32'h10);
    check("conc_pending", 32'(pending),   32'h1);
    check("conc_o4",      32'(o[4]),      32'h4444);
    check("conc_ovw",     32'(overwrite), 32'h0);

    // Reset in the middle of operation drops the concurrent write
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 8'h00);
    for (int i = 2; i < 6; i++) begin
      cyc(1'b0, 1'b1, 3'(i), 16'h2000 + 16'(i), 8'h00);
    end
    check("mid_pre_valid",   32'(valid),   32'h3C);
    check("mid_pre_pending", 32'(pending), 32'h4);
    cyc(1'b1, 1'b1, 3'd0, 16'h5555, 8'h00);
    check_all_zero("midrst");

    // First edge after reset accepts a write
    cyc(1'b0, 1'b1, 3'd6, 16'h6666, 8'h00);
    check("post_o6",      32'(o[6]),    32'h6666);
    check("post_valid",   32'(valid),   32'h40);
    check("post_pending", 32'(pending), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_demux8.md
RESULT_DEMUX8 -- requirements
Module: result_demux8

Interface
REQ-001 Parameter WIDTH, default 16, data width of the input and of every output slot.
REQ-002 Parameter NSLOT, fixed at 8, number of destination slots; the 3-bit select addresses slots 0-7.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in  input  WIDTH  result word to be routed.
REQ-006 control  input  3  destination slot index for the current write.
REQ-007 wr_en  input  1  write strobe; when high, in is captured into slot control on this edge.
REQ-008 clr  input  8  per-slot consume/clear strobes; bit i high clears valid[i].
REQ-009 o0..o7  output  WIDTH each  registered slot contents.
REQ-010 valid  output  8  per-slot "holds unconsumed data" flags.
REQ-011 pending  output  4  registered count of set valid bits, range 0-8.
REQ-012 overwrite  output  1  one-cycle pulse flagging that unconsumed data was lost.

Function
REQ-013 Write: with wr_en=1 at an edge, o[control] SHALL take in and valid[control] SHALL become 1; the other slots SHALL be unchanged.
REQ-014 Write latency SHALL be one cycle: the new value is visible on o[control] immediately after the capturing edge.
REQ-015 Clear: with clr[i]=1 at an edge, valid[i] SHALL become 0 and o_i SHALL retain its data.
REQ-016 Simultaneous write and clear on the same slot: the write SHALL win, so valid stays 1 with new data and overwrite stays 0.
REQ-017 Clears on slots other than the written slot SHALL take effect in the same cycle as the write.
REQ-018 Any number of clr bits MAY be asserted together; each SHALL clear independently.
REQ-019 overwrite SHALL be 1 for exactly the cycle after an edge where wr_en=1, valid[control]=1 and clr[control]=0; otherwise it SHALL be 0.
REQ-020 When an overwrite occurs, the write SHALL still proceed.
REQ-021 pending SHALL equal popcount(valid) at all times, updated on the same edge as valid, with no extra cycle of lag.
REQ-022 pending SHALL saturate naturally at 8, with no wrap; 4 bits hold 0-8.
REQ-023 When wr_en=0 and clr=0, all state SHALL hold.
REQ-024 Every control value 0-7 SHALL be a legal slot; there is no default or discard path.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from input to output.

Reset
REQ-026 When rst=1 at an edge, o0..o7 SHALL become 0, valid SHALL become 8'h00, pending SHALL become 0 and overwrite SHALL become 0.
REQ-027 rst SHALL take priority over wr_en and clr in the same cycle; a write arriving during reset is dropped.
REQ-028 Reset asserted mid-operation SHALL discard all slot data; there is no partial preservation.
REQ-029 On the first edge after rst deasserts, the block SHALL accept writes normally.

Structure
REQ-030 The shared package SHALL hold the WIDTH default, the NSLOT=8 constant and the select width (3).
REQ-031 The per-slot data register plus valid flag SHALL be a sub-module, demux_slot, instantiated 8 times.
REQ-032 Select decode, the overwrite flop and the pending counter logic SHALL live in the top module.

Verification
REQ-033 Reset: rst=1 for 2 cycles with wr_en=1, in=16'hFFFF -> all o=0, valid=00, pending=0, overwrite=0.
REQ-034 Fill: write 16'h1000+i to slot i for i=0..7 on consecutive cycles -> o_i=16'h1000+i, valid=FF, pending steps 1..8, overwrite never set.
REQ-035 Overwrite:
  - write 16'hABCD to slot 3, then 16'h1234 to slot 3 with clr=0 -> o3=16'h1234, overwrite=1 for one cycle, pending=1;
  - repeating with clr[3]=1 on the second write -> overwrite=0.
REQ-036 Clear:
  - slots 0, 5 and 7 valid; clr=8'hA1 -> valid=00, pending=0;
  - o0, o5 and o7 retain their data.
REQ-037 Concurrent:
  - slots 1 and 2 valid; write slot 4 with clr=8'h06 -> valid=8'h10, pending=1 after a single edge.
REQ-038 Mid-reset: valid=8'h3C, then rst=1 for one cycle while wr_en=1 targets slot 0 -> everything is 0 afterwards, including o0.
